// File: rtl/acumulador_pkg.sv
// Shared definitions for the parameterised accumulator controller.
// Holds the FSM state encoding and the default parameter values used by
// control_acumulador_param and divisor_frecuencia.
package acumulador_pkg;

    localparam int ANCHO_DEF   = 4;
    localparam int DIVISOR_DEF = 100000000;
    localparam int N_SUMAS_DEF = 5;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        LISTO   = 2'd2
    } estado_t;

endpackage

// File: rtl/divisor_frecuencia.sv
// Frequency divider producing the accumulation tick and a 50%-duty clk_out.
// Ports:
//   clk100MHz  in   system clock, all state changes on its rising edge
//   reset      in   synchronous, active-high
//   tick       out  high for the single cycle in which div_cnt = DIVISOR-1
//   clk_out    out  registered square wave, period DIVISOR cycles; falls
//                   on the edge that ends each tick cycle
module divisor_frecuencia
    import acumulador_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic clk100MHz,
    input  logic reset,
    output logic tick,
    output logic clk_out
);

    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_FIN   = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_MITAD = CW'(DIVISOR / 2 - 1);

    logic [CW-1:0] div_cnt;

    assign tick = (div_cnt == CNT_FIN);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else begin
            if (div_cnt == CNT_FIN) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
            // Toggling at the half-way point and at the wrap gives 50% duty
            // and makes the tick edge a falling edge of clk_out.
            if ((div_cnt == CNT_MITAD) || (div_cnt == CNT_FIN)) begin
                clk_out <= ~clk_out;
            end
        end
    end

endmodule

// File: rtl/control_acumulador_param.sv
// Tick-paced accumulator controller.
// On each divider tick the FSM (REPOSO -> SUMANDO -> LISTO) loads and then
// accumulates entradaSuma N_SUMAS times, wrapping or saturating on overflow.
// Ports:
//   clk100MHz        in   system clock
//   reset            in   synchronous, active-high
//   inicio           in   run request, level-sensitive, sampled on ticks
//   modo_saturacion  in   1 = clamp at all-ones, 0 = wrap modulo 2^ANCHO
//   entradaSuma      in   addend, sampled on ticks
//   clk_out          out  divided clock, period DIVISOR cycles
//   Resultado        out  registered accumulator value
//   listo            out  registered, high while in LISTO
//   desborde         out  registered sticky overflow flag for the run
module control_acumulador_param
    import acumulador_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int N_SUMAS = N_SUMAS_DEF
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic             inicio,
    input  logic             modo_saturacion,
    input  logic [ANCHO-1:0] entradaSuma,
    output logic             clk_out,
    output logic [ANCHO-1:0] Resultado,
    output logic             listo,
    output logic             desborde
);

    localparam int CW = $clog2(N_SUMAS + 1);
    localparam logic [CW-1:0]    CUENTA_FIN = CW'(N_SUMAS);
    localparam logic [ANCHO-1:0] MAXIMO     = {ANCHO{1'b1}};

    logic             tick;
    estado_t          estado;
    logic [CW-1:0]    cuenta;
    logic [CW-1:0]    cuenta_sig;
    logic [ANCHO:0]   suma;
    logic [ANCHO-1:0] suma_ajustada;

    divisor_frecuencia #(
        .DIVISOR(DIVISOR)
    ) u_divisor (
        .clk100MHz(clk100MHz),
        .reset    (reset),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    // NOTE: every signal driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch can be inferred.
    always_comb begin
        suma          = {1'b0, Resultado} + {1'b0, entradaSuma};
        cuenta_sig    = cuenta + CW'(1);
        suma_ajustada = suma[ANCHO-1:0];
        if (suma[ANCHO] && modo_saturacion) begin
            suma_ajustada = MAXIMO;
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            estado    <= REPOSO;
            cuenta    <= '0;
            Resultado <= '0;
            listo     <= 1'b0;
            desborde  <= 1'b0;
        end else if (tick) begin
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        Resultado <= entradaSuma;
                        cuenta    <= CW'(1);
                        desborde  <= 1'b0;
                        if (N_SUMAS == 1) begin
                            estado <= LISTO;
                            listo  <= 1'b1;
                        end else begin
                            estado <= SUMANDO;
                        end
                    end
                end

                SUMANDO: begin
                    if (inicio) begin
                        Resultado <= suma_ajustada;
                        cuenta    <= cuenta_sig;
                        // Sticky: only ever set during a run, cleared on load.
                        if (suma[ANCHO]) begin
                            desborde <= 1'b1;
                        end
                        if (cuenta_sig == CUENTA_FIN) begin
                            estado <= LISTO;
                            listo  <= 1'b1;
                        end
                    end else begin
                        // Abort keeps the partial result and flag visible.
                        estado <= REPOSO;
                        cuenta <= '0;
                    end
                end

                LISTO: begin
                    // Result frozen; a low inicio re-arms for the next run.
                    if (!inicio) begin
                        estado <= REPOSO;
                        cuenta <= '0;
                        listo  <= 1'b0;
                    end
                end

                default: begin
                    estado <= REPOSO;
                    cuenta <= '0;
                    listo  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_acumulador_param.sv
// Self-checking bench for control_acumulador_param (ANCHO=4, DIVISOR=4,
// N_SUMAS=5). A behavioural model tracks the divider phase and the run
// (active/finished, addition count, accumulated value) using plain integer
// arithmetic and is advanced once per clock edge.
module tb_control_acumulador_param;

    localparam int ANCHO   = 4;
    localparam int DIVISOR = 4;
    localparam int N_SUMAS = 5;
    localparam int MAXV    = (1 << ANCHO) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             inicio;
    logic             modo_saturacion;
    logic [ANCHO-1:0] entradaSuma;
    logic             clk_out;
    logic [ANCHO-1:0] Resultado;
    logic             listo;
    logic             desborde;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt, m_acc, m_n;
    bit m_clk, m_running, m_done, m_ovf, m_tick;

    int tab_wrap [5] = '{5, 10, 15, 4, 9};
    int tab_sat  [5] = '{5, 10, 15, 15, 15};

    control_acumulador_param #(
        .ANCHO  (ANCHO),
        .DIVISOR(DIVISOR),
        .N_SUMAS(N_SUMAS)
    ) dut (
        .clk100MHz      (clk),
        .reset          (reset),
        .inicio         (inicio),
        .modo_saturacion(modo_saturacion),
        .entradaSuma    (entradaSuma),
        .clk_out        (clk_out),
        .Resultado      (Resultado),
        .listo          (listo),
        .desborde       (desborde)
    );

    always #5 clk = ~clk;

    task automatic aplicar_tick();
        int s;
        if (m_done) begin
            if (!inicio) begin
                m_done = 0;
                m_n    = 0;
            end
        end else if (m_running) begin
            if (inicio) begin
                s = m_acc + int'(entradaSuma);
                if (s > MAXV) begin
                    m_ovf = 1;
                    m_acc = modo_saturacion ? MAXV : s % (MAXV + 1);
                end else begin
                    m_acc = s;
                end
                m_n++;
                if (m_n == N_SUMAS) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end else begin
                m_running = 0;
                m_n       = 0;
            end
        end else if (inicio) begin
            m_acc = int'(entradaSuma);
            m_n   = 1;
            m_ovf = 0;
            if (N_SUMAS == 1) m_done = 1;
            else m_running = 1;
        end
    endtask

    // Advance one clock edge, update the model, then settle 1 time unit.
    task automatic ciclo();
        @(posedge clk);
        m_tick = 0;
        if (reset) begin
            m_cnt = 0; m_clk = 0; m_running = 0; m_done = 0;
            m_acc = 0; m_n = 0; m_ovf = 0;
        end else begin
            if (m_cnt == DIVISOR / 2 - 1 || m_cnt == DIVISOR - 1) m_clk = !m_clk;
            if (m_cnt == DIVISOR - 1) begin
                m_tick = 1;
                aplicar_tick();
            end
            m_cnt = (m_cnt + 1) % DIVISOR;
        end
        #1;
    endtask

    task automatic hasta_tick();
        int n = 0;
        do begin
            ciclo();
            n++;
        end while (!m_tick && n < 2 * DIVISOR);
        checks++;
        if (!m_tick) begin
            errors++;
            $display("FAIL tick_timeout: no tick within %0d cycles", n);
        end
    endtask

    task automatic reiniciar();
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inicio = 1'b0; modo_saturacion = 1'b0; entradaSuma = '0;
        ciclo();
        ciclo();
        checks++;
        if ({Resultado, listo, desborde, clk_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got R=%0d listo=%b desb=%b clk_out=%b, required all 0",
                     Resultado, listo, desborde, clk_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_divisor();
        // i edges after the reset edge: clk_out = (i/2) mod 2
        for (int i = 1; i <= 12; i++) begin
            ciclo();
            checks++;
            if (clk_out !== 1'(((i / 2) % 2))) begin
                errors++;
                $display("FAIL divisor_clk_out cycle %0d: got %b required %b",
                         i, clk_out, ((i / 2) % 2));
            end
        end
    endtask

    task automatic test_run(input bit sat);
        reiniciar();
        modo_saturacion = sat; entradaSuma = 4'd5; inicio = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            hasta_tick();
            checks++;
            if (int'(Resultado) !== (sat ? tab_sat[k-1] : tab_wrap[k-1])) begin
                errors++;
                $display("FAIL run_resultado sat=%0d tick %0d: got %0d required %0d",
                         sat, k, Resultado, sat ? tab_sat[k-1] : tab_wrap[k-1]);
            end
            checks++;
            if (desborde !== (k >= 4)) begin
                errors++;
                $display("FAIL run_desborde sat=%0d tick %0d: got %b required %b", sat, k, desborde, k >= 4);
            end
            checks++;
            if (listo !== (k == 5)) begin
                errors++;
                $display("FAIL run_listo sat=%0d tick %0d: got %b required %b", sat, k, listo, k == 5);
            end
        end
        // Completed run stays frozen while inicio is held, whatever the addend.
        for (int k = 0; k < 2; k++) begin
            entradaSuma = 4'($urandom_range(MAXV));
            hasta_tick();
            checks++;
            if (int'(Resultado) !== (sat ? 15 : 9) || listo !== 1'b1) begin
                errors++;
                $display("FAIL listo_hold sat=%0d: got R=%0d listo=%b required R=%0d listo=1",
                         sat, Resultado, listo, sat ? 15 : 9);
            end
        end
        // One low tick re-arms, the next high tick starts afresh.
        inicio = 1'b0;
        hasta_tick();
        checks++;
        if (listo !== 1'b0 || int'(Resultado) !== (sat ? 15 : 9)) begin
            errors++;
            $display("FAIL rearm sat=%0d: got R=%0d listo=%b required R=%0d listo=0",
                     sat, Resultado, listo, sat ? 15 : 9);
        end
        inicio = 1'b1; entradaSuma = 4'd7;
        hasta_tick();
        checks++;
        if (Resultado !== 4'd7 || listo !== 1'b0 || desborde !== 1'b0) begin
            errors++;
            $display("FAIL fresh_run sat=%0d: got R=%0d listo=%b desb=%b required R=7 listo=0 desb=0",
                     sat, Resultado, listo, desborde);
        end
    endtask

    task automatic test_abort();
        reiniciar();
        modo_saturacion = 1'b0; entradaSuma = 4'd5; inicio = 1'b1;
        hasta_tick();
        hasta_tick();
        inicio = 1'b0;
        entradaSuma = 4'd3;
        hasta_tick();
        checks++;
        if (Resultado !== 4'd10 || listo !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: got R=%0d listo=%b required R=10 listo=0", Resultado, listo);
        end
        // Still idle: another low tick must not touch the result.
        hasta_tick();
        checks++;
        if (Resultado !== 4'd10) begin
            errors++;
            $display("FAIL abort_idle: got R=%0d required 10", Resultado);
        end
        inicio = 1'b1; entradaSuma = 4'd5;
        hasta_tick();
        checks++;
        if (Resultado !== 4'd5 || desborde !== 1'b0 || listo !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: got R=%0d desb=%b listo=%b required R=5 desb=0 listo=0",
                     Resultado, desborde, listo);
        end
        hasta_tick();
        checks++;
        if (Resultado !== 4'd10) begin
            errors++;
            $display("FAIL abort_second_sum: got R=%0d required 10", Resultado);
        end
    endtask

    task automatic test_reset_mid();
        reiniciar();
        modo_saturacion = 1'b0; entradaSuma = 4'd5; inicio = 1'b1;
        hasta_tick();
        hasta_tick();
        ciclo();
        ciclo();
        reset = 1'b1;
        ciclo();
        checks++;
        if ({Resultado, listo, desborde, clk_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got R=%0d listo=%b desb=%b clk_out=%b required all 0",
                     Resultado, listo, desborde, clk_out);
        end
        reset = 1'b0; entradaSuma = 4'd3;
        for (int i = 1; i <= DIVISOR; i++) begin
            ciclo();
            checks++;
            if (Resultado !== ((i == DIVISOR) ? 4'd3 : 4'd0)) begin
                errors++;
                $display("FAIL first_tick_after_reset edge %0d: got R=%0d required %0d",
                         i, Resultado, (i == DIVISOR) ? 3 : 0);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        reiniciar();
        for (int c = 0; c < 1200; c++) begin
            if (m_cnt == 1) begin
                inicio          = ($urandom_range(9) != 0);
                modo_saturacion = 1'($urandom_range(1));
                entradaSuma     = 4'($urandom_range(MAXV));
            end
            ciclo();
            checks++;
            if (int'(Resultado) !== m_acc || listo !== m_done ||
                desborde !== m_ovf || clk_out !== m_clk) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d: got R=%0d listo=%b desb=%b clk_out=%b required R=%0d listo=%b desb=%b clk_out=%b",
                             c, Resultado, listo, desborde, clk_out, m_acc, m_done, m_ovf, m_clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_run(1'b0);
        test_run(1'b1);
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
